mema_load_seq: RTL
==================

Name: mema_load_seq

Overview:
- Upstream feeder and sequencer for the A-side skew memory of the systolic TPU datapath.
- Accepts a valid/ready stream of signed BITS_AB-bit matrix elements in row-major order.
- Packs each DIM elements into one row and writes it into the A memory through WrEn/Arow/Ain.
- After all DIM rows are written, asserts en for RUN_CYCLES cycles so the skewed columns drain into the MAC array, then pulses done.

Parameters:
- BITS_AB, 8, element width in bits (signed).
- DIM, 8, matrix dimension: elements per row and rows per matrix.
- RUN_CYCLES, 3*DIM-2, number of consecutive en cycles in the run phase (22 at DIM=8).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- start  input  1  one-cycle request to begin loading a matrix; honoured only in IDLE.
- in_valid  input  1  in_data carries a valid element.
- in_data  input  BITS_AB signed  element; row-major, matrix[0][0] first.
- in_ready  output  1  block accepts in_data this cycle.
- WrEn  output  1  one-cycle row write strobe to the A memory.
- Arow  output  $clog2(DIM)  matrix row index for the current write.
- Ain  output  DIM x BITS_AB signed  packed row; matrix column 0 sits at Ain[DIM-1], column DIM-1 at Ain[0].
- en  output  1  shift enable to the A memory and MAC array.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the run phase completes.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk, rising edge.
- Reset values: state=IDLE; in_ready, WrEn, en, busy and done all 0; Arow=0; every Ain element=0; elem_cnt, row_cnt, run_cnt and the pack register all 0.
- States and transitions:
  - IDLE -> LOAD when start=1.
  - LOAD -> RUN on the cycle after the last row's WrEn.
  - RUN -> DONE when run_cnt reaches RUN_CYCLES-1.
  - DONE -> IDLE unconditionally after one cycle.
- start outside IDLE is ignored with no side effects.
- LOAD:
  - in_ready=1 until the DIM*DIM-th element is accepted, then 0 for the rest of the operation.
  - A transfer occurs when in_valid & in_ready at the clock edge.
  - Each transfer stores in_data into pack[DIM-1-elem_cnt] and increments elem_cnt.
  - On the DIM-th transfer of a row:
    - Ain is loaded with the completed row, including the element accepted on that edge.
    - Arow is loaded with row_cnt.
    - WrEn=1 for exactly the next cycle.
    - elem_cnt wraps to 0 and row_cnt increments.
  - Streaming continues without a bubble: the first element of the next row can be accepted in the same cycle WrEn is high.
  - Ain and Arow hold their values until the next row completes.
  - in_valid=0 leaves all counters unchanged; stalls of any length are allowed.
  - en=0 throughout LOAD.
- Transition to RUN: the last row completes at edge k, WrEn=1 in cycle k+1, and en=1 starts in cycle k+2.
- RUN:
  - en=1 for exactly RUN_CYCLES consecutive cycles; run_cnt counts 0..RUN_CYCLES-1.
  - in_ready=0 and WrEn=0 throughout.
- DONE: done=1 and en=0 for one cycle; busy stays 1 in this cycle.
- Return to IDLE: row_cnt, elem_cnt and run_cnt clear to 0. Ain and Arow keep their last values.
- Widths: elem_cnt and row_cnt are $clog2(DIM) bits and wrap naturally. run_cnt is $clog2(RUN_CYCLES) bits. in_data passes through with no arithmetic or sign change.
- Reset mid-operation, in any state: immediately return to the reset values above. Partially packed data is discarded and no WrEn or done is emitted.
- en and WrEn are never high in the same cycle.

Test Plan:
- Reset check: assert rst_n=0 mid-LOAD -> in_ready, WrEn, en, busy, done = 0 and all Ain elements = 0 immediately (asynchronously); after release, the first start begins loading from row 0.
- Back-to-back load, DIM=8: start, then stream elements 1..64 with in_valid held 1:
  - 8 WrEn pulses appear, spaced 8 cycles apart.
  - The first pulse has Arow=0, Ain[7]=1, Ain[0]=8.
  - The last pulse has Arow=7, Ain[7]=57, Ain[0]=64.
- Run phase: after the final WrEn, en=1 for exactly 22 cycles starting one cycle after WrEn, then done=1 for one cycle, then busy=0.
- Stalled stream: toggle in_valid 1/0 every cycle while sending 1..64 -> the same Arow/Ain sequence as back-to-back, with WrEn pulses 16 cycles apart and no data loss.
- Negative values: send -128 as element 0 and 127 as element 7 of row 3 -> on the Arow=3 pulse, Ain[7]=8'h80 and Ain[0]=8'h7F, with no sign corruption.
- Ignored start: pulse start during LOAD and during RUN -> no counter restarts, the WrEn count stays 8 and the run length stays 22.

Source files
------------

// File: rtl/mema_load_seq.sv
// Feeder/sequencer for the A-side skew memory: packs a row-major element
// stream into rows, writes them to the A memory, then runs the drain phase.
module mema_load_seq #(
   parameter int unsigned BITS_AB    = 8,
   parameter int unsigned DIM        = 8,
   parameter int unsigned RUN_CYCLES = 3*DIM-2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              in_valid,
   input  logic signed [BITS_AB-1:0]         in_data,
   output logic                              in_ready,
   output logic                              WrEn,
   output logic [$clog2(DIM)-1:0]            Arow,
   output logic signed [DIM-1:0][BITS_AB-1:0] Ain,
   output logic                              en,
   output logic                              busy,
   output logic                              done
);

   localparam int unsigned CW = $clog2(DIM);
   localparam int unsigned RW = $clog2(RUN_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef logic [DIM-1:0][BITS_AB-1:0] row_t;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] elem_cnt, elem_cnt_nxt;
   logic [CW-1:0] row_cnt, row_cnt_nxt;
   logic [RW-1:0] run_cnt, run_cnt_nxt;
   row_t          pack, pack_nxt;
   row_t          ain_nxt;
   logic [CW-1:0] arow_nxt;
   logic          in_ready_nxt, wren_nxt, en_nxt, busy_nxt, done_nxt;
   logic [CW-1:0] slot;
   logic          xfer;

   // Column 0 lands in the top slot of the packed row.
   assign slot = CW'(DIM-1) - elem_cnt;
   assign xfer = in_valid & in_ready;

   // Next-state and next-output logic.
   always_comb begin
      state_nxt    = state;
      elem_cnt_nxt = elem_cnt;
      row_cnt_nxt  = row_cnt;
      run_cnt_nxt  = run_cnt;
      pack_nxt     = pack;
      ain_nxt      = row_t'(Ain);
      arow_nxt     = Arow;
      in_ready_nxt = in_ready;
      wren_nxt     = 1'b0;
      en_nxt       = en;
      busy_nxt     = busy;
      done_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt    = S_LOAD;
               in_ready_nxt = 1'b1;
               busy_nxt     = 1'b1;
            end
         end
         S_LOAD: begin
            if (xfer) begin
               pack_nxt[slot] = in_data;
               if (elem_cnt == CW'(DIM-1)) begin
                  elem_cnt_nxt = '0;
                  ain_nxt      = pack_nxt;
                  arow_nxt     = row_cnt;
                  wren_nxt     = 1'b1;
                  row_cnt_nxt  = (row_cnt == CW'(DIM-1)) ? '0 : row_cnt + CW'(1);
                  if (row_cnt == CW'(DIM-1))
                     in_ready_nxt = 1'b0;
               end else begin
                  elem_cnt_nxt = elem_cnt + CW'(1);
               end
            end else if (!in_ready) begin
               // Last row's WrEn is on the bus this cycle; drain starts next.
               state_nxt   = S_RUN;
               en_nxt      = 1'b1;
               run_cnt_nxt = '0;
            end
         end
         S_RUN: begin
            if (run_cnt == RW'(RUN_CYCLES-1)) begin
               state_nxt = S_DONE;
               en_nxt    = 1'b0;
               done_nxt  = 1'b1;
            end else begin
               run_cnt_nxt = run_cnt + RW'(1);
            end
         end
         S_DONE: begin
            state_nxt    = S_IDLE;
            busy_nxt     = 1'b0;
            elem_cnt_nxt = '0;
            row_cnt_nxt  = '0;
            run_cnt_nxt  = '0;
         end
         default: begin
            state_nxt    = S_IDLE;
            in_ready_nxt = 1'b0;
            en_nxt       = 1'b0;
            busy_nxt     = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         elem_cnt <= '0;
         row_cnt  <= '0;
         run_cnt  <= '0;
         pack     <= '0;
         Ain      <= '0;
         Arow     <= '0;
         in_ready <= 1'b0;
         WrEn     <= 1'b0;
         en       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         elem_cnt <= elem_cnt_nxt;
         row_cnt  <= row_cnt_nxt;
         run_cnt  <= run_cnt_nxt;
         pack     <= pack_nxt;
         Ain      <= ain_nxt;
         Arow     <= arow_nxt;
         in_ready <= in_ready_nxt;
         WrEn     <= wren_nxt;
         en       <= en_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

endmodule
